traffic_light_controller: RTL and testbench
===========================================

// Module: traffic_light_controller
// PURPOSE
//  Moore FSM for a two-road intersection (Academic Ave = A, Bravado Blvd = B).
//  - Inputs: per-road traffic sensors.
//  - Outputs: 2-bit light codes for each road.
//  - Green stays on a road while that road's sensor is active.
//  - On green hand-off, an amber phase lasts a fixed number of cycles.
//  - Standalone leaf block; driven by the system clock.
// PARAMETERS
//  YELLOW_CYCLES  5  clock cycles each amber phase lasts (>=1)
//  TW             3  timer width; must satisfy 2**TW > YELLOW_CYCLES
// PORTS
//  clk        in   1  system clock, rising edge
//  reset      in   1  asynchronous, active-high reset
//  traffic_A  in   1  1 = vehicles waiting/passing on Academic Ave
//  traffic_B  in   1  1 = vehicles waiting/passing on Bravado Blvd
//  LA         out  2  Academic Ave light: 2'b00 GREEN, 2'b01 YELLOW, 2'b10 RED
//  LB         out  2  Bravado Blvd light, same encoding; 2'b11 never driven
// BEHAVIOUR
//  Clock/reset:
//  - One clock domain (clk).
//  - reset is asynchronous, active-high; it may assert at any time, mid-phase
//    included.
//  - Reset values: state = S0, timer = 0, LA = GREEN, LB = RED.
//  - First transition is on the first rising clk edge after reset deasserts.
//  States (Moore; LA/LB are pure decodes of the state register):
//  - S0: LA GREEN,  LB RED
//  - S1: LA YELLOW, LB RED
//  - S2: LA RED,    LB GREEN
//  - S3: LA RED,    LB YELLOW
//  Transitions, evaluated at each rising clk edge:
//  - S0: traffic_A = 1 -> stay in S0; traffic_A = 0 -> S1, timer cleared to 0.
//  - S1: timer increments each cycle; when timer == YELLOW_CYCLES-1 -> S2.
//    S1 therefore lasts exactly YELLOW_CYCLES cycles.
//  - S2: traffic_B = 1 -> stay in S2; traffic_B = 0 -> S3, timer cleared to 0.
//  - S3: same timing as S1, then -> S0.
//  Sensor rules:
//  - Sensors are ignored during S1/S3; an amber phase always completes.
//  - Both sensors high: the current green holds indefinitely (A priority
//    in S0, B priority in S2).
//  - Both sensors low: lights cycle continuously
//    (S0 -> S1 -> S2 -> S3 -> S0 ...).
//  Safety and timing:
//  - Never both roads non-RED at the same time.
//  - Every change from GREEN to RED passes through YELLOW.
//  - Latency: a sensor drop is reflected in the lights one edge later.
//  - Sensors are treated as synchronous to clk; no internal synchronizer.
//  - Timer is held at 0 outside S1/S3 and never wraps.
//  - Illegal state encodings recover to S0 on the next edge.
// STRUCTURE
//  Shared package:
//  - Light encoding localparams LIGHT_GREEN / LIGHT_YELLOW / LIGHT_RED.
//  - State typedef/encoding S0..S3 (2-bit).
//  Sub-module:
//  - tlc_phase_timer: clear/enable up-counter with terminal-count flag, width TW.
//  Top level contains:
//  - State register (async reset).
//  - Next-state logic.
//  - Output decode.
// TESTING
//  1) Reset with both sensors at 0, hold 1 cycle -> LA = 00, LB = 10 while
//     reset is high, with no clk edge required.
//  2) Release reset, traffic_A = 1 for 5 cycles -> LA = 00, LB = 10
//     throughout (holds green).
//  3) traffic_A = 0, traffic_B = 1:
//     - Next edge: LA = 01.
//     - 5 cycles later: LA = 10, LB = 00.
//     - LB stays 00 while traffic_B = 1.
//  4) traffic_B = 0:
//     - LB = 01 for exactly 5 cycles.
//     - Then LA = 00, LB = 10.
//     - With both sensors 0 the sequence repeats with period 12 cycles
//       (1 + 5 + 1 + 5).
//  5) Assert reset mid-S1 (LA = 01) -> immediately LA = 00, LB = 10;
//     timer restarts from 0 on the next amber phase.
//  6) Both sensors = 1 in S0 for 20 cycles -> LA = 00 held.
//     Assertion over all tests: never (LA != 10 && LB != 10); never a 11 code.

Source files
------------

// File: rtl/traffic_light_controller_pkg.sv
// Shared light encoding, controller state type and light decode helpers
// for the two-road traffic light controller.
package traffic_light_controller_pkg;

   localparam logic [1:0] LIGHT_GREEN  = 2'b00;
   localparam logic [1:0] LIGHT_YELLOW = 2'b01;
   localparam logic [1:0] LIGHT_RED    = 2'b10;

   typedef enum logic [1:0] {
      S0 = 2'b00,  // A green,  B red
      S1 = 2'b01,  // A yellow, B red
      S2 = 2'b10,  // A red,    B green
      S3 = 2'b11   // A red,    B yellow
   } state_e;

   function automatic logic [1:0] light_a(input state_e s);
      case (s)
         S0:      light_a = LIGHT_GREEN;
         S1:      light_a = LIGHT_YELLOW;
         default: light_a = LIGHT_RED;
      endcase
   endfunction

   function automatic logic [1:0] light_b(input state_e s);
      case (s)
         S2:      light_b = LIGHT_GREEN;
         S3:      light_b = LIGHT_YELLOW;
         default: light_b = LIGHT_RED;
      endcase
   endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Amber phase timer: clear/enable up-counter with a registered terminal-count
// flag that is high whenever the count equals TERM-1.
module tlc_phase_timer #(
   parameter int unsigned TW   = 3,
   parameter int unsigned TERM = 5
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [TW-1:0] LAST = TW'(TERM - 1);

   logic [TW-1:0] count_q, count_d;
   logic          tc_q;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + TW'(1);
      end
   end

   // Flag tracks the next count so it is aligned with count_q.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
         tc_q    <= (LAST == '0);
      end else begin
         count_q <= count_d;
         tc_q    <= (count_d == LAST);
      end
   end

   assign tc_o = tc_q;

endmodule

// File: rtl/traffic_light_controller.sv
// Moore traffic light controller for the Academic Ave / Bravado Blvd crossing:
// green holds while its sensor is active, hand-off goes through a timed amber.
module traffic_light_controller
   import traffic_light_controller_pkg::*;
#(
   parameter int unsigned YELLOW_CYCLES = 5,
   parameter int unsigned TW            = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       traffic_A,
   input  logic       traffic_B,
   output logic [1:0] LA,
   output logic [1:0] LB
);

   state_e     state_q, state_d;
   logic [1:0] la_q, lb_q;
   logic       timer_clr, timer_en, timer_tc;

   tlc_phase_timer #(
      .TW   (TW),
      .TERM (YELLOW_CYCLES)
   ) u_phase_timer (
      .clk_i (clk),
      .rst_i (reset),
      .clr_i (timer_clr),
      .en_i  (timer_en),
      .tc_o  (timer_tc)
   );

   // Timer counts only during amber and is cleared on leaving it, so it never wraps.
   always_comb begin
      state_d   = state_q;
      timer_clr = 1'b1;
      timer_en  = 1'b0;
      case (state_q)
         S0: if (!traffic_A) state_d = S1;
         S1: begin
            timer_clr = timer_tc;
            timer_en  = 1'b1;
            if (timer_tc) state_d = S2;
         end
         S2: if (!traffic_B) state_d = S3;
         S3: begin
            timer_clr = timer_tc;
            timer_en  = 1'b1;
            if (timer_tc) state_d = S0;
         end
         default: state_d = S0;
      endcase
   end

   // Lights are registered alongside the state so they always equal its decode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S0;
         la_q    <= LIGHT_GREEN;
         lb_q    <= LIGHT_RED;
      end else begin
         state_q <= state_d;
         la_q    <= light_a(state_d);
         lb_q    <= light_b(state_d);
      end
   end

   assign LA = la_q;
   assign LB = lb_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller with a road-level reference
// model compared every cycle, plus literal checks pinning key timings.
module tb_traffic_light_controller;

   localparam int unsigned YC = 5;
   localparam logic [1:0] G = 2'b00;
   localparam logic [1:0] Y = 2'b01;
   localparam logic [1:0] R = 2'b10;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ta = 1'b0;
   logic       tb_s = 1'b0;
   logic [1:0] la, lb;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   traffic_light_controller #(
      .YELLOW_CYCLES (YC),
      .TW            (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .traffic_A (ta),
      .traffic_B (tb_s),
      .LA        (la),
      .LB        (lb)
   );

   task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Road-level model: which road owns the green and how many amber cycles remain.
   bit m_green_a;
   int m_amber;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_green_a <= 1'b1;
         m_amber   <= 0;
      end else if (m_amber > 0) begin
         m_amber <= m_amber - 1;
         if (m_amber == 1) m_green_a <= !m_green_a;
      end else if (m_green_a ? !ta : !tb_s) begin
         m_amber <= YC;
      end
   end

   function automatic logic [1:0] model_light(input bit is_a);
      if (is_a == m_green_a) return (m_amber > 0) ? Y : G;
      return R;
   endfunction

   always begin
      @(posedge clk);
      #3;
      checks++;
      if ((la != R && lb != R) || la == 2'b11 || lb == 2'b11) begin
         failures++;
         $display("FAIL safety: LA=%b LB=%b at %0t", la, lb, $time);
      end
      if (!reset) begin
         check2("model_LA", la, model_light(1'b1));
         check2("model_LB", lb, model_light(1'b0));
      end
   end

   initial begin
      int  n;
      bit  seen;

      // 1) async reset without a clock edge
      #2 reset = 1'b1;
      #1;
      check2("reset_LA", la, G);
      check2("reset_LB", lb, R);
      @(negedge clk);
      check2("reset_hold_LA", la, G);
      ta = 1'b1;
      reset = 1'b0;

      // 2) A sensor holds green
      repeat (5) begin
         @(posedge clk); #1;
         check2("holdA_LA", la, G);
         check2("holdA_LB", lb, R);
      end

      // 3) hand-off to B
      @(negedge clk);
      ta = 1'b0;
      tb_s = 1'b1;
      @(posedge clk); #1;
      check2("amberA_first_LA", la, Y);
      repeat (4) @(posedge clk);
      #1;
      check2("amberA_last_LA", la, Y);
      @(posedge clk); #1;
      check2("greenB_LA", la, R);
      check2("greenB_LB", lb, G);
      repeat (6) begin
         @(posedge clk); #1;
         check2("holdB_LB", lb, G);
      end

      // 4) B amber length, then continuous cycling period
      @(negedge clk);
      tb_s = 1'b0;
      @(posedge clk); #1;
      n = 0;
      while (lb == Y && n < 20) begin
         n++;
         @(posedge clk); #1;
      end
      check_int("amberB_len", n, 5);
      check2("backA_LA", la, G);
      check2("backA_LB", lb, R);
      n = 0;
      seen = 1'b0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (la != G) seen = 1'b1;
         else if (seen) break;
      end
      check_int("cycle_period", n, 12);

      // 5) reset in the middle of an amber phase
      @(posedge clk); #1;
      check2("amber_again_LA", la, Y);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check2("midamber_reset_LA", la, G);
      check2("midamber_reset_LB", lb, R);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      n = 0;
      while (la == Y && n < 20) begin
         n++;
         @(posedge clk); #1;
      end
      check_int("amber_after_reset_len", n, 5);

      // 6) both sensors high in S0 hold A green
      @(negedge clk);
      reset = 1'b1;
      ta = 1'b1;
      tb_s = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         check2("both_high_LA", la, G);
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
